// File: rtl/led_phy_pkg.sv
// rtl/led_phy_pkg.sv - shared types and constants for the LED PHY frame path
package led_phy_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUM  = 3'd1,
    MUL  = 3'd2,
    DONE = 3'd3
  } frame_calc_state_t;

  typedef enum logic {
    TAIL_FIXED = 1'b0,
    TAIL_COUNT = 1'b1
  } tail_mode_t;

  localparam int TAIL_DIV_SHIFT = 4;

endpackage

// File: rtl/led_shift_add_mul.sv
// rtl/led_shift_add_mul.sv - multi-cycle shift-add multiply by a constant, LSB first
// done/product flag the final iteration combinationally so the caller can register the result on that edge.
module led_shift_add_mul
  import led_phy_pkg::*;
#(
  parameter int MULT_CONST = 32,
  parameter int IN_W       = 10,
  parameter int ACC_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  multiplicand,
  output logic             done,
  output logic [ACC_W-1:0] product
);

  localparam int MUL_W = $clog2(MULT_CONST + 1);
  localparam int CNT_W = $clog2(MUL_W + 1);
  localparam logic [MUL_W-1:0] MULT_BITS = MUL_W'(MULT_CONST);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  mcand_q, mcand_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [MUL_W-1:0] bits_shifted;

  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    acc_d        = acc_q;
    bits_shifted = MULT_BITS >> cnt_q;
    product      = acc_q + (bits_shifted[0] ? (ACC_W'(mcand_q) << cnt_q) : ACC_W'(0));
    done         = busy_q && (cnt_q == CNT_W'(MUL_W - 1));
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
      mcand_d = multiplicand;
    end else if (busy_q) begin
      acc_d = product;
      cnt_d = cnt_q + CNT_W'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/led_frame_len_calc.sv
// rtl/led_frame_len_calc.sv - handshaked LED PHY frame length calculator with saturation
module led_frame_len_calc
  import led_phy_pkg::*;
#(
  parameter int NUM_W      = 8,
  parameter int RES_W      = 16,
  parameter int HDR_WORDS  = 1,
  parameter int TAIL_WORDS = 1,
  parameter int WORD_BITS  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NUM_W-1:0] led_num,
  input  logic             tail_mode,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             ovf
);

  localparam int NW2   = NUM_W + 2;
  localparam int MUL_W = $clog2(WORD_BITS + 1);
  localparam int ACC_W = RES_W + MUL_W + NUM_W + 2;

  frame_calc_state_t state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  tail_mode_t        mode_q, mode_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic [NW2-1:0]    tail, tail_cnt, wc;
  logic              mul_done;
  logic [ACC_W-1:0]  mul_product;
  logic              sat;

  always_comb begin
    tail_cnt = (NW2'(num_q) + NW2'((1 << TAIL_DIV_SHIFT) - 1)) >> TAIL_DIV_SHIFT;
    if (mode_q == TAIL_FIXED) tail = NW2'(TAIL_WORDS);
    else if (tail_cnt == '0)  tail = NW2'(1);
    else                      tail = tail_cnt;
    wc  = NW2'(HDR_WORDS) + NW2'(num_q) + tail;
    sat = |mul_product[ACC_W-1:RES_W];
  end

  led_shift_add_mul #(
    .MULT_CONST (WORD_BITS),
    .IN_W       (NW2),
    .ACC_W      (ACC_W)
  ) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (state_q == SUM),
    .multiplicand (wc),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SUM;
          num_d   = led_num;
          mode_d  = tail_mode_t'(tail_mode);
        end
      end
      SUM:  state_d = MUL;
      MUL: begin
        if (mul_done) begin
          state_d  = DONE;
          done_d   = 1'b1;
          ovf_d    = sat;
          result_d = sat ? {RES_W{1'b1}} : mul_product[RES_W-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      mode_q   <= TAIL_FIXED;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/led_frame_len_calc.md
# led_frame_len_calc

Parametrised, handshaked calculator for the LED PHY frame length in bits, computed as (HDR_WORDS + led_num + tail_words) × WORD_BITS.
- It supports a fixed tail and a count-dependent tail.
- It accepts a new request after each result.
- It saturates with an overflow flag.
- It sits between the LED configuration registers and the LED PHY bit serialiser.
- The multiply is done with a multi-cycle shift-add so no DSP/multiplier is inferred.

## Interface
Parameters:
- NUM_W, 8: width of led_num (max LEDs 2^NUM_W − 1).
- RES_W, 16: width of result.
- HDR_WORDS, 1: header words per frame; must be < 2^NUM_W.
- TAIL_WORDS, 1: tail words in fixed-tail mode; must be < 2^NUM_W.
- WORD_BITS, 32: bits per word, ≥ 1.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when the block can accept a request.
- led_num  in  NUM_W  LED count; sampled only on accept.
- tail_mode  in  1  0 = fixed TAIL_WORDS; 1 = count-dependent tail.
- done  out  1  one-cycle pulse: result is valid.
- result  out  RES_W  frame length in bits; held until the next done.
- ovf  out  1  true product exceeded RES_W; qualifies result; held with result.

## Operation
- Accept: req_valid & req_ready on a rising edge. At that edge, led_num and tail_mode are captured into internal registers. Inputs are ignored at all other times.
- Tail rule: in mode 0, tail = TAIL_WORDS. In mode 1, tail = (led_num + 15) >> 4, with a minimum of 1.
- Word count: wc = HDR_WORDS + led_num + tail, computed at NUM_W+2 bits. It never wraps.
- Multiply: shift-add over the bits of the constant WORD_BITS, LSB first.
  - MUL_W = $clog2(WORD_BITS+1) iterations.
  - Accumulator width: RES_W + MUL_W + NUM_W + 2. It never wraps.
- Saturation: if the product is ≥ 2^RES_W, result = all ones and ovf = 1. Otherwise result = product and ovf = 0.
- FSM states and transitions:
  - IDLE: req_ready = 1. On accept → SUM.
  - SUM: compute wc and clear the accumulator. → MUL.
  - MUL: one iteration per cycle. After MUL_W cycles → DONE.
  - DONE: done = 1. → IDLE.
  - Any illegal state → IDLE.
- req_ready = (state == IDLE). Requests made while busy are not queued; they are simply not accepted.
- result and ovf are written only at the edge entering DONE.
- Reset values: req_ready = 1 (state IDLE), done = 0, result = 0, ovf = 0. All internal registers are 0.
- Reset mid-operation: the block returns to IDLE immediately. No done pulse is produced, and result/ovf read 0.

## Timing
- Accept at edge k → SUM occupies cycle k+1 → MUL occupies MUL_W cycles → at edge k+1+MUL_W, result/ovf update and done rises.
- done stays high for exactly one cycle. req_ready rises at edge k+2+MUL_W.
- With defaults (MUL_W = 6), done is first sampled high at edge k+8, i.e. 7 cycles after the accept edge.
- Back-to-back: with req_valid held high, the next accept occurs on the first edge where req_ready = 1. Throughput is one result per MUL_W+3 cycles.
- led_num may change freely after the accept edge without affecting the result in flight.

## Structure
- The shared package led_phy_pkg holds:
  - typedef enum logic [2:0] frame_calc_state_t (IDLE, SUM, MUL, DONE);
  - typedef enum logic tail_mode_t (TAIL_FIXED, TAIL_COUNT);
  - localparam TAIL_DIV_SHIFT = 4.
- Sub-module led_shift_add_mul holds the shift-add multiplier.
  - Ports: start, multiplicand, done.
  - Constant multiplier via parameter.
- The FSM, tail/word-count logic and saturation stay in the top module.

## Test plan
Defaults apply unless stated.
1. Reset: assert rst_n = 0 with req_valid high → req_ready = 1, done = 0, result = 0, ovf = 0; no accept occurs during reset.
2. Mode 0, led_num = 30: accept → done exactly 7 cycles later, result = 1024, ovf = 0; done is high for one cycle, result is held afterwards.
3. Mode 1 tail cases:
   - led_num = 100 → tail 7, wc 108 → result = 3456.
   - led_num = 0 → tail 1 → result = 64.
4. Overflow with RES_W = 12, mode 0, led_num = 255: product 8224 → result = 4095, ovf = 1. The next request, led_num = 10 (result 384), clears ovf.
5. Busy handling: pulse req_valid with led_num = 50 during MUL → ignored, result from the original request only. Hold req_valid high → back-to-back accepts every 9 cycles.
6. Reset mid-MUL: drop rst_n for one cycle → IDLE, no done pulse, result = 0. A subsequent request completes normally.
